// File: rtl/m_pinreduce_harness_if.sv
// Pin-side bundle of the pin-reduction harness: serial expander input, observed
// core buses and the signature readout.
interface m_pinreduce_harness_if #(
   parameter int IWIDTH = 32,
   parameter int OWIDTH = 32,
   parameter int NBUS   = 2
);
   logic                     ser_i;
   logic                     ser_en_i;
   logic [IWIDTH-1:0]        dat_o;
   logic [NBUS*OWIDTH-1:0]   obs_i;
   logic                     obs_vld_i;
   logic                     clr_i;
   logic                     unload_i;
   logic                     busy_o;
   logic                     sig_o;

   modport master (
      output ser_i, ser_en_i, obs_i, obs_vld_i, clr_i, unload_i,
      input  dat_o, busy_o, sig_o
   );

   modport slave (
      input  ser_i, ser_en_i, obs_i, obs_vld_i, clr_i, unload_i,
      output dat_o, busy_o, sig_o
   );
endinterface

// File: rtl/m_pinreduce_harness.sv
// Pin-reduction harness: serial-to-parallel DAT_I expander plus a MISR that folds the
// observed core buses into a signature shifted out on one pin. Optional HARNESS_SAMPLECNT_EN.
module m_pinreduce_harness #(
   parameter int               IWIDTH = 32,
   parameter int               OWIDTH = 32,
   parameter int               NBUS   = 2,
   parameter int               MISRW  = 16,
   parameter logic [MISRW-1:0] POLY   = 16'h1021
) (
   input logic                CLK_I,
   input logic                RST_N_I,
   m_pinreduce_harness_if.slave bus
);

`ifdef HARNESS_SAMPLECNT_EN
   localparam int ULEN = MISRW + 16;
`else
   localparam int ULEN = MISRW;
`endif
   localparam int CW     = $clog2(ULEN);
   localparam int TOTW   = NBUS * OWIDTH;
   localparam int NCHUNK = (TOTW + MISRW - 1) / MISRW;
   localparam int PADW   = NCHUNK * MISRW;

   typedef enum logic {IDLE, UNLOAD} state_t;

   logic [IWIDTH-1:0] dat_q, dat_shift;
   logic [MISRW-1:0]  misr_q, misr_next, fold;
   logic [PADW-1:0]   obs_pad;
   logic              parity_q;
   logic [ULEN-1:0]   shadow_q, shadow_d, snap;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d;
   state_t            state_q, state_d;

   generate
      if (IWIDTH == 1) begin : g_one
         assign dat_shift = bus.ser_i;
      end else begin : g_wide
         assign dat_shift = {dat_q[IWIDTH-2:0], bus.ser_i};
      end
   endgenerate

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I)
         dat_q <= '0;
      else if (bus.ser_en_i)
         dat_q <= dat_shift;
   end

   // Upper chunk is zero-padded so any bus width folds into whole MISR words.
   assign obs_pad = PADW'(bus.obs_i);

   always_comb begin
      fold = '0;
      for (int i = 0; i < NCHUNK; i++)
         fold = fold ^ obs_pad[i*MISRW +: MISRW];
   end

   always_comb begin
      misr_next = misr_q;
      if (bus.clr_i)
         misr_next = '0;
      else if (bus.obs_vld_i)
         misr_next = {misr_q[MISRW-2:0], 1'b0} ^ (misr_q[MISRW-1] ? POLY : '0) ^ fold;
   end

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         misr_q   <= '0;
         parity_q <= 1'b0;
      end else begin
         misr_q   <= misr_next;
         parity_q <= ^misr_q;
      end
   end

`ifdef HARNESS_SAMPLECNT_EN
   logic [15:0] count_q;

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I)
         count_q <= '0;
      else if (bus.clr_i)
         count_q <= '0;
      else if (bus.obs_vld_i)
         count_q <= count_q + 16'd1;
   end

   assign snap = {misr_q, count_q};
`else
   assign snap = misr_q;
`endif

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   // The snapshot takes the pre-edge MISR, so compression can run on during unload.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      case (state_q)
         IDLE: begin
            if (bus.unload_i) begin
               shadow_d = snap;
               cnt_d    = CW'(ULEN - 1);
               busy_d   = 1'b1;
               state_d  = UNLOAD;
            end
         end
         UNLOAD: begin
            shadow_d = {shadow_q[ULEN-2:0], 1'b0};
            if (cnt_q == '0) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.dat_o  = dat_q;
   assign bus.busy_o = busy_q;
   assign bus.sig_o  = busy_q ? shadow_q[ULEN-1] : parity_q;

endmodule
